// File: rtl/skin_bbox.sv
// Skin-tone classifier and per-frame bounding-box tracker for a raster YUV pixel stream.
// One result record per frame is handed to the host over a valid/ack handshake.
module skin_bbox #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int CW    = 19,
    parameter int Y_MIN = 0,
    parameter int U_MIN = 73,
    parameter int U_MAX = 122,
    parameter int V_MIN = 132,
    parameter int V_MAX = 173
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic          i_sof,
    input  logic [7:0]    i_y,
    input  logic [7:0]    i_u,
    input  logic [7:0]    i_v,
    output logic          o_skind,
    output logic          o_skind_vld,
    output logic          o_res_valid,
    input  logic          i_res_ack,
    output logic [CW-1:0] o_count,
    output logic [XW-1:0] o_xmin,
    output logic [XW-1:0] o_xmax,
    output logic [YW-1:0] o_ymin,
    output logic [YW-1:0] o_ymax,
    output logic          o_box_vld,
    output logic          o_sync_err,
    output logic          o_overrun
);

    typedef enum logic {ACCUM = 1'b0, FLUSH = 1'b1} state_t;

    state_t        state;
    logic [XW-1:0] x, acc_xmin, acc_xmax, px, b_xmin, b_xmax, n_xmin, n_xmax;
    logic [YW-1:0] y, acc_ymin, acc_ymax, py, b_ymin, b_ymax, n_ymin, n_ymax;
    logic [CW-1:0] acc_cnt, b_cnt, n_cnt;
    logic          skin, sync_hit, last, clr, nz;

    // Unsigned a >= b via the borrow bit, so a zero threshold does not degenerate to a constant compare.
    function automatic logic ge(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        return !d[8];
    endfunction

    always_comb begin
        skin = ge(i_y, 8'(Y_MIN)) && ge(i_u, 8'(U_MIN)) && ge(8'(U_MAX), i_u) &&
               ge(i_v, 8'(V_MIN)) && ge(8'(V_MAX), i_v);
        sync_hit = i_valid && i_sof && ((x != '0) || (y != '0));
        // A misplaced start-of-frame restarts the raster at the origin.
        px   = sync_hit ? '0 : x;
        py   = sync_hit ? '0 : y;
        last = (px == XW'(IMG_W - 1)) && (py == YW'(IMG_H - 1));
        nz   = (acc_cnt != '0);
    end

    // The accumulators restart on FLUSH (record handed off) or on a sync error (partial frame dropped);
    // the pixel accepted in that same cycle lands in the fresh accumulators.
    always_comb begin
        clr    = (state == FLUSH) || sync_hit;
        b_cnt  = clr ? '0 : acc_cnt;
        b_xmin = clr ? '1 : acc_xmin;
        b_xmax = clr ? '0 : acc_xmax;
        b_ymin = clr ? '1 : acc_ymin;
        b_ymax = clr ? '0 : acc_ymax;
        n_cnt  = b_cnt;
        n_xmin = b_xmin;
        n_xmax = b_xmax;
        n_ymin = b_ymin;
        n_ymax = b_ymax;
        if (i_valid && skin) begin
            n_cnt = b_cnt + CW'(1);
            if (px < b_xmin) n_xmin = px;
            if (px > b_xmax) n_xmax = px;
            if (py < b_ymin) n_ymin = py;
            if (py > b_ymax) n_ymax = py;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ACCUM;
            x           <= '0;
            y           <= '0;
            acc_cnt     <= '0;
            acc_xmin    <= '1;
            acc_xmax    <= '0;
            acc_ymin    <= '1;
            acc_ymax    <= '0;
            o_skind     <= 1'b0;
            o_skind_vld <= 1'b0;
            o_sync_err  <= 1'b0;
            o_res_valid <= 1'b0;
            o_overrun   <= 1'b0;
            o_count     <= '0;
            o_box_vld   <= 1'b0;
            o_xmin      <= '0;
            o_xmax      <= '0;
            o_ymin      <= '0;
            o_ymax      <= '0;
        end else begin
            o_skind_vld <= i_valid;
            o_skind     <= i_valid && skin;
            o_sync_err  <= sync_hit;
            acc_cnt     <= n_cnt;
            acc_xmin    <= n_xmin;
            acc_xmax    <= n_xmax;
            acc_ymin    <= n_ymin;
            acc_ymax    <= n_ymax;
            state       <= (i_valid && last) ? FLUSH : ACCUM;

            if (i_valid) begin
                if (last) begin
                    x <= '0;
                    y <= '0;
                end else if (px == XW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= py + YW'(1);
                end else begin
                    x <= px + XW'(1);
                    y <= py;
                end
            end

            if (state == FLUSH) begin
                // A same-cycle ack frees the slot, so the new record loading is not an overrun.
                o_res_valid <= 1'b1;
                if (o_res_valid && !i_res_ack) o_overrun <= 1'b1;
                o_count   <= acc_cnt;
                o_box_vld <= nz;
                o_xmin    <= nz ? acc_xmin : '0;
                o_xmax    <= nz ? acc_xmax : '0;
                o_ymin    <= nz ? acc_ymin : '0;
                o_ymax    <= nz ? acc_ymax : '0;
            end else if (i_res_ack) begin
                o_res_valid <= 1'b0;
            end
        end
    end

endmodule
